// File: rtl/con_pkg.sv
// -----------------------------------------------------------------------------
// con_pkg -- shared definitions for the condition unit.
//   cond_e  : condition-select encodings carried in the IR cond field.
//   state_e : control FSM state encoding (IDLE -> EVAL -> HOLD -> IDLE).
// -----------------------------------------------------------------------------
package con_pkg;

    localparam int COND_W = 3;

    typedef enum logic [COND_W-1:0] {
        COND_ZERO    = 3'd0,  // value == 0
        COND_NONZERO = 3'd1,  // value != 0
        COND_POS     = 3'd2,  // MSB == 0
        COND_NEG     = 3'd3,  // MSB == 1
        COND_POS_NZ  = 3'd4,  // MSB == 0 and value != 0
        COND_NEG_Z   = 3'd5,  // MSB == 1 or value == 0
        COND_ALWAYS  = 3'd6,
        COND_NEVER   = 3'd7
    } cond_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

endpackage

// File: rtl/con_eval.sv
// -----------------------------------------------------------------------------
// con_eval -- combinational branch-condition decode.
//   op   : captured bus value (DATA_W bits); zero test spans every bit,
//          sign is taken from bit DATA_W-1 only.
//   cond : condition-select field (con_pkg::cond_e encoding).
//   flag : 1 when the selected condition holds.
// -----------------------------------------------------------------------------
module con_eval
    import con_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] op,
    input  logic [2:0]        cond,
    output logic              flag
);

    logic is_zero_s;
    logic is_neg_s;

    assign is_zero_s = ~(|op);
    assign is_neg_s  = op[DATA_W-1];

    // Select the condition result for the requested encoding.
    always_comb begin
        flag = 1'b0;
        case (cond_e'(cond))
            COND_ZERO:    flag = is_zero_s;
            COND_NONZERO: flag = ~is_zero_s;
            COND_POS:     flag = ~is_neg_s;
            COND_NEG:     flag = is_neg_s;
            COND_POS_NZ:  flag = ~is_neg_s & ~is_zero_s;
            COND_NEG_Z:   flag = is_neg_s | is_zero_s;
            COND_ALWAYS:  flag = 1'b1;
            COND_NEVER:   flag = 1'b0;
            default:      flag = 1'b0;
        endcase
    end

endmodule

// File: rtl/con_unit.sv
// -----------------------------------------------------------------------------
// con_unit -- branch condition unit with capture / evaluate / hold handshake.
//   clk          : system clock, rising edge.
//   clr          : synchronous active-low reset.
//   cond         : condition-select field from the IR.
//   busout       : bus value under test.
//   CONin        : capture strobe (honoured in IDLE, or in HOLD together with ack).
//   con_ack      : control consumed the result (honoured only in HOLD).
//   CONout       : registered branch-taken flag, retained after the handshake.
//   con_valid    : CONout is fresh and unconsumed.
//   busy         : FSM is not in IDLE.
//   taken_cnt    : saturating count of taken evaluations.
//   nottaken_cnt : saturating count of not-taken evaluations.
// Optional feature: the counters exist only when CON_UNIT_STATS_EN is
// defined; otherwise both count ports read constant zero.
// -----------------------------------------------------------------------------
module con_unit
    import con_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [2:0]        cond,
    input  logic [DATA_W-1:0] busout,
    input  logic              CONin,
    input  logic              con_ack,
    output logic              CONout,
    output logic              con_valid,
    output logic              busy,
    output logic [CNT_W-1:0]  taken_cnt,
    output logic [CNT_W-1:0]  nottaken_cnt
);

    state_e            state_q,  state_d;
    logic [DATA_W-1:0] op_q,     op_d;
    logic [2:0]        cond_q,   cond_d;
    logic              conout_q, conout_d;
    logic              valid_q,  valid_d;
    logic              busy_q,   busy_d;
    logic              flag_s;

    con_eval #(.DATA_W(DATA_W)) u_eval (
        .op   (op_q),
        .cond (cond_q),
        .flag (flag_s)
    );

    // Next-state and datapath decisions for the capture/eval/hold handshake.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cond_d   = cond_q;
        conout_d = conout_q;
        valid_d  = valid_q;
        case (state_q)
            ST_IDLE: begin
                if (CONin) begin
                    op_d    = busout;
                    cond_d  = cond;
                    state_d = ST_EVAL;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EVAL: begin
                conout_d = flag_s;
                valid_d  = 1'b1;
                state_d  = ST_HOLD;
            end
            ST_HOLD: begin
                if (con_ack) begin
                    valid_d = 1'b0;
                    // A new strobe alongside the ack skips IDLE entirely.
                    if (CONin) begin
                        op_d    = busout;
                        cond_d  = cond;
                        state_d = ST_EVAL;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // Control and datapath registers with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q  <= ST_IDLE;
            op_q     <= {DATA_W{1'b0}};
            cond_q   <= 3'd0;
            conout_q <= 1'b0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cond_q   <= cond_d;
            conout_q <= conout_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
        end
    end

    assign CONout    = conout_q;
    assign con_valid = valid_q;
    assign busy      = busy_q;

`ifdef CON_UNIT_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] taken_q, taken_d;
    logic [CNT_W-1:0] ntaken_q, ntaken_d;

    // One saturating increment per evaluation, steered by the new flag.
    always_comb begin
        taken_d  = taken_q;
        ntaken_d = ntaken_q;
        if (state_q == ST_EVAL) begin
            if (flag_s) begin
                taken_d = (taken_q == CNT_MAX) ? taken_q : taken_q + CNT_ONE;
            end else begin
                ntaken_d = (ntaken_q == CNT_MAX) ? ntaken_q : ntaken_q + CNT_ONE;
            end
        end else begin
            taken_d  = taken_q;
            ntaken_d = ntaken_q;
        end
    end

    // Statistics counter registers.
    always_ff @(posedge clk) begin
        if (!clr) begin
            taken_q  <= {CNT_W{1'b0}};
            ntaken_q <= {CNT_W{1'b0}};
        end else begin
            taken_q  <= taken_d;
            ntaken_q <= ntaken_d;
        end
    end

    assign taken_cnt    = taken_q;
    assign nottaken_cnt = ntaken_q;
`else
    assign taken_cnt    = {CNT_W{1'b0}};
    assign nottaken_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_con_unit.sv
// -----------------------------------------------------------------------------
// tb_con_unit -- self-checking bench for con_unit (DATA_W=32, CNT_W=4).
// Expected flags come from a vector table; each capture pushes its expected
// flag to a queue that is popped when con_valid appears.
// -----------------------------------------------------------------------------
module tb_con_unit;

    localparam int DW = 32;
    localparam int CW = 4;
`ifdef CON_UNIT_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          clr;
    logic [2:0]    cond;
    logic [DW-1:0] busout;
    logic          CONin;
    logic          con_ack;
    logic          CONout;
    logic          con_valid;
    logic          busy;
    logic [CW-1:0] taken_cnt;
    logic [CW-1:0] nottaken_cnt;

    always #5 clk = ~clk;

    con_unit #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk          (clk),
        .clr          (clr),
        .cond         (cond),
        .busout       (busout),
        .CONin        (CONin),
        .con_ack      (con_ack),
        .CONout       (CONout),
        .con_valid    (con_valid),
        .busy         (busy),
        .taken_cnt    (taken_cnt),
        .nottaken_cnt (nottaken_cnt)
    );

    typedef struct {
        logic [2:0]    c;
        logic [DW-1:0] b;
        bit            exp;
    } vec_t;

    int errors = 0;
    int checks = 0;
    bit exp_q[$];
    int m_taken = 0;
    int m_ntaken = 0;
    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance through one rising edge and settle at the following falling edge.
    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic int sat_inc(input int v);
        return (v >= (1 << CW) - 1) ? v : v + 1;
    endfunction

    task automatic model_count(input bit t);
        if (t) m_taken = sat_inc(m_taken);
        else   m_ntaken = sat_inc(m_ntaken);
    endtask

    task automatic capture(input logic [2:0] c, input logic [DW-1:0] b, input bit exp);
        cond   = c;
        busout = b;
        CONin  = 1'b1;
        exp_q.push_back(exp);
        model_count(exp);
        tick;
        chk("eval_busy", busy, 1);
        chk("eval_valid", con_valid, 0);
        CONin = 1'b0;
    endtask

    task automatic expect_result(input string name);
        tick;
        chk("hold_valid", con_valid, 1);
        if (con_valid && exp_q.size() > 0) begin
            chk(name, CONout, exp_q.pop_front());
        end else begin
            checks++;
            errors++;
            $display("FAIL %s: no result (valid=%0b queued=%0d) expected a result", name, con_valid, exp_q.size());
        end
    endtask

    task automatic ack_release(input bit exp_out);
        con_ack = 1'b1;
        tick;
        con_ack = 1'b0;
        chk("ack_valid", con_valid, 0);
        chk("ack_busy", busy, 0);
        chk("ack_conout", CONout, exp_out);
    endtask

    task automatic check_counters(input string tag);
        chk({tag, "_taken"},  taken_cnt,    STATS ? m_taken  : 0);
        chk({tag, "_ntaken"}, nottaken_cnt, STATS ? m_ntaken : 0);
    endtask

    initial begin
        vecs[0]  = '{3'd0, 32'h0000_0000, 1'b1};
        vecs[1]  = '{3'd3, 32'h8000_0000, 1'b1};
        vecs[2]  = '{3'd4, 32'h8000_0000, 1'b0};
        vecs[3]  = '{3'd6, 32'h1234_5678, 1'b1};
        vecs[4]  = '{3'd7, 32'hFFFF_FFFF, 1'b0};
        vecs[5]  = '{3'd1, 32'h0000_0000, 1'b0};
        vecs[6]  = '{3'd1, 32'h0000_0005, 1'b1};
        vecs[7]  = '{3'd2, 32'h7FFF_FFFF, 1'b1};
        vecs[8]  = '{3'd2, 32'h0000_0000, 1'b1};
        vecs[9]  = '{3'd4, 32'h0000_0000, 1'b0};
        vecs[10] = '{3'd5, 32'h0000_0000, 1'b1};
        vecs[11] = '{3'd5, 32'h0000_0001, 1'b0};
        vecs[12] = '{3'd5, 32'h8000_0000, 1'b1};
        vecs[13] = '{3'd0, 32'h0000_0100, 1'b0};
        vecs[14] = '{3'd1, 32'h8000_0000, 1'b1};
        vecs[15] = '{3'd3, 32'h0000_0001, 1'b0};

        // Reset with strobes asserted: they must be ignored.
        clr = 1'b0; cond = 3'd6; busout = 32'h0; CONin = 1'b1; con_ack = 1'b1;
        @(negedge clk);
        tick;
        chk("rst_busy", busy, 0);
        chk("rst_valid", con_valid, 0);
        chk("rst_conout", CONout, 0);
        check_counters("rst");
        clr = 1'b1; CONin = 1'b0; con_ack = 1'b0;
        tick;
        chk("idle_busy", busy, 0);

        // Table-driven decode coverage.
        for (int i = 0; i < 16; i++) begin
            capture(vecs[i].c, vecs[i].b, vecs[i].exp);
            expect_result($sformatf("vec%0d_conout", i));
            ack_release(vecs[i].exp);
        end
        check_counters("table");

        // con_ack in IDLE does nothing.
        con_ack = 1'b1;
        tick;
        con_ack = 1'b0;
        chk("idle_ack_busy", busy, 0);
        chk("idle_ack_valid", con_valid, 0);

        // Back-to-back: ack and new strobe together in HOLD.
        capture(3'd1, 32'h0, 1'b0);
        expect_result("b2b_first");
        con_ack = 1'b1; CONin = 1'b1; busout = 32'h5; cond = 3'd1;
        exp_q.push_back(1'b1);
        model_count(1'b1);
        tick;
        con_ack = 1'b0; CONin = 1'b0;
        chk("b2b_busy", busy, 1);
        chk("b2b_valid", con_valid, 0);
        chk("b2b_conout_kept", CONout, 0);
        expect_result("b2b_second");
        ack_release(1'b1);

        // Strobes in EVAL and in HOLD without ack are ignored.
        capture(3'd0, 32'h0, 1'b1);
        CONin = 1'b1; cond = 3'd7; busout = 32'hFFFF;
        expect_result("ign_eval");
        for (int k = 0; k < 2; k++) begin
            tick;
            chk("ign_hold_valid", con_valid, 1);
            chk("ign_hold_conout", CONout, 1);
            chk("ign_hold_busy", busy, 1);
        end
        CONin = 1'b0;
        ack_release(1'b1);
        chk("queue_empty", exp_q.size(), 0);
        check_counters("seq");

        // Reset in EVAL overrides the in-flight evaluation.
        cond = 3'd6; busout = 32'h1; CONin = 1'b1;
        tick;
        chk("clr_pre_busy", busy, 1);
        clr = 1'b0; con_ack = 1'b1;
        tick;
        chk("clr_busy", busy, 0);
        chk("clr_valid", con_valid, 0);
        chk("clr_conout", CONout, 0);
        m_taken = 0; m_ntaken = 0;
        check_counters("clr");
        clr = 1'b1; CONin = 1'b0; con_ack = 1'b0;
        tick;
        chk("clr_after_busy", busy, 0);

        // Saturation: 17 taken evaluations.
        for (int n = 0; n < 17; n++) begin
            capture(3'd6, $urandom, 1'b1);
            expect_result("sat_conout");
            ack_release(1'b1);
        end
        chk("sat_model", m_taken, 15);
        check_counters("sat");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/con_unit.md
CON_UNIT -- requirements
Module: con_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning the width of the tested bus value.
REQ-002 SHALL have parameter CNT_W, default 16, meaning the width of the statistics counters.
REQ-003 SHALL have port clk, input, 1, meaning the single system clock; all state changes on the rising edge.
REQ-004 SHALL have port clr, input, 1, meaning reset; one clock, reset synchronous and active-low.
REQ-005 SHALL have port cond, input, 3, meaning the condition-select field from the IR.
REQ-006 SHALL have port busout, input, DATA_W, meaning the bus value under test.
REQ-007 SHALL have port CONin, input, 1, meaning the capture strobe from control.
REQ-008 SHALL have port con_ack, input, 1, meaning control has consumed the result.
REQ-009 SHALL have port CONout, output, 1, meaning the branch-taken flag.
REQ-010 SHALL have port con_valid, output, 1, meaning CONout holds a fresh, unconsumed result.
REQ-011 SHALL have port busy, output, 1, meaning the unit is not in IDLE.
REQ-012 SHALL have ports taken_cnt and nottaken_cnt, output, CNT_W, meaning the outcome counters.

Function
REQ-013 SHALL decode cond as: 0 zero; 1 nonzero; 2 positive (MSB=0); 3 negative (MSB=1); 4 positive and nonzero; 5 negative or zero; 6 always; 7 never.
REQ-014 SHALL implement FSM IDLE -> EVAL -> HOLD -> IDLE.
REQ-015 SHALL, in IDLE with CONin=1, register busout and cond and enter EVAL.
REQ-016 SHALL, in EVAL, load CONout from the registered operands, set con_valid=1, and enter HOLD; CONin in EVAL is ignored.
REQ-017 SHALL give a latency of two edges: CONin sampled at edge N produces CONout/con_valid valid after edge N+1.
REQ-018 SHALL, in HOLD, keep CONout and con_valid stable until con_ack=1.
REQ-019 SHALL, in HOLD with con_ack=1 and CONin=0, clear con_valid and return to IDLE, retaining CONout.
REQ-020 SHALL, in HOLD with con_ack=1 and CONin=1, clear con_valid, capture new operands, and enter EVAL (back-to-back).
REQ-021 SHALL ignore CONin in HOLD without con_ack.
REQ-022 SHALL ignore con_ack outside HOLD.
REQ-023 SHALL evaluate zero over all DATA_W bits and sign from bit DATA_W-1 only.

Reset
REQ-024 SHALL, on a clk edge with clr=0, force IDLE, CONout=0, con_valid=0, busy=0, captured operands=0, and both counters=0, overriding any in-flight operation.
REQ-025 SHALL ignore CONin and con_ack on the reset edge.

Configuration
REQ-026 SHALL compile the statistics counters only when CON_UNIT_STATS_EN is defined.
REQ-027 SHALL, with the macro defined, increment taken_cnt (CONout=1) or nottaken_cnt (CONout=0) once per EVAL, saturating at all-ones.
REQ-028 SHALL, without the macro, keep the ports present and tie both counters to 0.

Structure
REQ-029 SHALL place cond encodings (COND_ZERO..COND_NEVER) and the FSM state encoding in shared package con_pkg.
REQ-030 SHALL implement the decode as sub-module con_eval (combinational; operands and cond in, flag out).

Verification
REQ-031 SHALL cover: busout=0, cond=0, CONin pulse -> CONout=1, con_valid=1 two edges later; con_ack -> IDLE with CONout still 1.
REQ-032 SHALL cover: busout=32'h8000_0000, cond=3 then cond=4 -> CONout=1 then 0; cond=6/7 with any value -> 1/0.
REQ-033 SHALL cover: HOLD with con_ack=1 and CONin=1 simultaneously (busout=5, cond=1) -> straight to EVAL, CONout=1 one edge later with no IDLE cycle.
REQ-034 SHALL cover: CONin in EVAL and in HOLD without ack -> ignored; the result remains that of the first capture.
REQ-035 SHALL cover: clr=0 during EVAL -> next edge IDLE, CONout=0, con_valid=0, counters=0.
REQ-036 SHALL cover, with CON_UNIT_STATS_EN and CNT_W=4: 17 taken evaluations -> taken_cnt=4'hF (saturated), nottaken_cnt=0; without the macro both read 0.
